// File: rtl/mem_stage_pkg.sv
// Shared encodings and lane helpers for the MEM stage: access sizes, wait FSM
// states, byte-enable generation, store replication and load extension.
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {IDLE, WAIT} state_e;

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    logic m;
    case (sz)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = a[0];
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction

  // Lanes are replicated so the byte enables alone pick the destination bytes.
  function automatic logic [31:0] store_rep(input logic [31:0] sd, input logic [1:0] sz);
    logic [31:0] r;
    case (sz)
      SZ_BYTE: r = {4{sd[7:0]}};
      SZ_HALF: r = {2{sd[15:0]}};
      default: r = sd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_wb_dmem_bank.sv
// Word-organised data RAM with four byte write enables.
// Read is combinational; writes land on the rising clock edge. Contents are never reset.
module dmem_bank #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/mem_stage_wb.sv
// MIPS MEM stage: data memory access plus MEM/WB register. An access takes
// WAIT_STATES+1 cycles; mem_stall holds upstream until the completion edge.
module mem_stage_wb
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int REG_AW      = 5,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_wb_dest,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_unsigned,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              flush,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_alu_out,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [REG_AW-1:0] wb_dest,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic              wb_misalign
);

  localparam int         AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              access, is_mem, mis, stall_c, load_wb, complete, wr_en;
  logic [1:0]        lane;
  logic [AW-1:0]     widx;
  logic [31:0]       rdata, rd_ext;
  logic              unused_addr_hi;

  logic              wb_valid_q, wb_reg_write_q, wb_mem_to_reg_q, wb_misalign_q;
  logic [DATA_W-1:0] wb_alu_out_q, wb_read_data_q;
  logic [REG_AW-1:0] wb_dest_q;

  assign is_mem         = ex_mem_read | ex_mem_write;
  assign access         = ex_valid & is_mem & ~flush;
  assign lane           = ex_alu_out[1:0];
  assign widx           = ex_alu_out[AW+1:2];
  assign unused_addr_hi = ^ex_alu_out[DATA_W-1:AW+2];
  assign mis            = is_mem & misaligned(ex_mem_size, lane);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    load_wb  = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && (WS != 4'd0)) begin
          stall_c = 1'b1;
          state_d = WAIT;
          cnt_d   = 4'd1;
        end else if (ex_valid && !flush) begin
          load_wb  = 1'b1;
          complete = access;
        end
      end
      WAIT: begin
        // A flush abandons the access; the MEM/WB load that cycle is a bubble.
        if (flush) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == WS) begin
          load_wb  = 1'b1;
          complete = 1'b1;
          state_d  = IDLE;
          cnt_d    = 4'd0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_stall = stall_c & rst_n;
  assign wr_en     = complete & ex_mem_write & ~mis;
  assign rd_ext    = (ex_mem_read & ~ex_mem_write & ~mis)
                   ? load_ext(rdata, ex_mem_size, lane, ex_mem_unsigned) : 32'h0;

  dmem_bank #(.DEPTH(DEPTH), .AW(AW)) u_dmem (
    .clk_i   (clk),
    .we_i    (wr_en),
    .be_i    (byte_en(ex_mem_size, lane)),
    .addr_i  (widx),
    .wdata_i (store_rep(ex_store_data, ex_mem_size)),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= 4'd0;
      wb_valid_q      <= 1'b0;
      wb_alu_out_q    <= '0;
      wb_read_data_q  <= '0;
      wb_dest_q       <= '0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_misalign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_wb) begin
        wb_valid_q      <= 1'b1;
        wb_alu_out_q    <= ex_alu_out;
        wb_read_data_q  <= rd_ext;
        wb_dest_q       <= ex_wb_dest;
        wb_reg_write_q  <= ex_reg_write & ~mis;
        wb_mem_to_reg_q <= ex_mem_to_reg;
        wb_misalign_q   <= mis;
      end else begin
        wb_valid_q     <= 1'b0;
        wb_reg_write_q <= 1'b0;
        wb_misalign_q  <= 1'b0;
      end
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_alu_out    = wb_alu_out_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_dest       = wb_dest_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_misalign   = wb_misalign_q;

endmodule

// File: tb/tb_mem_stage_wb.sv
// Scoreboard bench: one instance with no wait states, one with three.
module tb_mem_stage_wb;
  import mem_stage_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic        rw;
    logic        m2r;
  } ex_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [4:0]  dest;
    logic        rw;
    logic        m2r;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst3_n, flush0, flush3;
  ex_t  ex0, ex3;
  logic stall0, v0, rw0, m2r0, mis0, stall3, v3, rw3, m2r3, mis3;
  logic [31:0] alu0, rd0, alu3, rd3;
  logic [4:0]  dest0, dest3;

  exp_t q0[$];
  exp_t q3[$];
  int checks = 0;
  int errors = 0;

  mem_stage_wb #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .ex_valid(ex0.valid), .ex_alu_out(ex0.addr),
    .ex_store_data(ex0.sd), .ex_wb_dest(ex0.dest), .ex_mem_read(ex0.rd),
    .ex_mem_write(ex0.wr), .ex_mem_size(ex0.size), .ex_mem_unsigned(ex0.uns),
    .ex_reg_write(ex0.rw), .ex_mem_to_reg(ex0.m2r), .flush(flush0),
    .mem_stall(stall0), .wb_valid(v0), .wb_alu_out(alu0), .wb_read_data(rd0),
    .wb_dest(dest0), .wb_reg_write(rw0), .wb_mem_to_reg(m2r0), .wb_misalign(mis0)
  );

  mem_stage_wb #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .ex_valid(ex3.valid), .ex_alu_out(ex3.addr),
    .ex_store_data(ex3.sd), .ex_wb_dest(ex3.dest), .ex_mem_read(ex3.rd),
    .ex_mem_write(ex3.wr), .ex_mem_size(ex3.size), .ex_mem_unsigned(ex3.uns),
    .ex_reg_write(ex3.rw), .ex_mem_to_reg(ex3.m2r), .flush(flush3),
    .mem_stall(stall3), .wb_valid(v3), .wb_alu_out(alu3), .wb_read_data(rd3),
    .wb_dest(dest3), .wb_reg_write(rw3), .wb_mem_to_reg(m2r3), .wb_misalign(mis3)
  );

  function automatic ex_t ld(input logic [31:0] a, input logic [1:0] sz,
                             input logic u, input logic [4:0] d);
    return '{1'b1, a, 32'h0, d, 1'b1, 1'b0, sz, u, 1'b1, 1'b1};
  endfunction

  function automatic ex_t st(input logic [31:0] a, input logic [31:0] sd, input logic [1:0] sz);
    return '{1'b1, a, sd, 5'd0, 1'b0, 1'b1, sz, 1'b0, 1'b0, 1'b0};
  endfunction

  function automatic exp_t xl(input logic [31:0] a, input logic [31:0] r, input logic [4:0] d);
    return '{a, r, d, 1'b1, 1'b1, 1'b0};
  endfunction

  function automatic exp_t xs(input logic [31:0] a);
    return '{a, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0};
  endfunction

  task automatic chk_b(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic cmp(input string nm, input exp_t g, input exp_t x);
    checks++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s: got alu=%h rd=%h dest=%0d rw=%b m2r=%b mis=%b expected alu=%h rd=%h dest=%0d rw=%b m2r=%b mis=%b",
               nm, g.alu, g.rdat, g.dest, g.rw, g.m2r, g.mis,
               x.alu, x.rdat, x.dest, x.rw, x.m2r, x.mis);
    end
  endtask

  // Monitor: every valid MEM/WB output is matched against the oldest expectation.
  always @(negedge clk) begin
    if (v0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb0_unexpected: got valid output alu=%h, required none", alu0);
      end else cmp("wb0", '{alu0, rd0, dest0, rw0, m2r0, mis0}, q0.pop_front());
    end
    if (v3 === 1'b1) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb3_unexpected: got valid output alu=%h, required none", alu3);
      end else cmp("wb3", '{alu3, rd3, dest3, rw3, m2r3, mis3}, q3.pop_front());
    end
  end

  task automatic issue0(input ex_t e, input exp_t x);
    ex0 = e;
    q0.push_back(x);
    @(negedge clk);
    chk_b("stall0", stall0, 1'b0);
    @(posedge clk); #1;
    ex0 = '0;
  endtask

  task automatic bubble0(input ex_t e, input logic fl);
    ex0 = e;
    flush0 = fl;
    @(negedge clk);
    chk_b("stall0_bubble", stall0, 1'b0);
    @(posedge clk); #1;
    ex0 = '0;
    flush0 = 1'b0;
    @(negedge clk);
    chk_b("bubble0_valid", v0, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic issue3(input ex_t e, input exp_t x);
    ex3 = e;
    q3.push_back(x);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_b("stall3", stall3, (k < 3));
      if (k > 0) chk_b("bubble3_valid", v3, 1'b0);
      @(posedge clk); #1;
    end
    ex3 = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst0_n = 1'b0; rst3_n = 1'b0;
    flush0 = 1'b0; flush3 = 1'b0;
    ex0 = '0; ex3 = '0;
    #12;
    chk_b("rst_valid0", v0, 1'b0);
    chk_w("rst_alu0", alu0, 32'h0);
    chk_w("rst_rd0", rd0, 32'h0);
    chk_w("rst_dest0", {27'h0, dest0}, 32'h0);
    chk_b("rst_flags0", rw0 | m2r0 | mis0, 1'b0);
    chk_b("rst_valid3", v3, 1'b0);
    chk_b("rst_stall3", stall3, 1'b0);
    @(negedge clk);
    rst0_n = 1'b1; rst3_n = 1'b1;
    @(posedge clk); #1;

    // Zero wait states: lanes, extension, misalignment, wrap, flush.
    issue0(st(32'h10, 32'hDEADBEEF, SZ_WORD), xs(32'h10));
    issue0(ld(32'h10, SZ_WORD, 1'b0, 5'd5), xl(32'h10, 32'hDEADBEEF, 5'd5));
    issue0(st(32'h20, 32'h11223344, SZ_WORD), xs(32'h20));
    issue0(st(32'h21, 32'h00000080, SZ_BYTE), xs(32'h21));
    issue0(ld(32'h21, SZ_BYTE, 1'b0, 5'd6), xl(32'h21, 32'hFFFFFF80, 5'd6));
    issue0(ld(32'h21, SZ_BYTE, 1'b1, 5'd7), xl(32'h21, 32'h00000080, 5'd7));
    issue0(ld(32'h20, SZ_WORD, 1'b0, 5'd8), xl(32'h20, 32'h11228044, 5'd8));
    begin
      ex_t e;
      e = st(32'h13, 32'h00001234, SZ_HALF);
      e.rw = 1'b1;
      issue0(e, '{32'h13, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1});
    end
    issue0(ld(32'h10, SZ_WORD, 1'b0, 5'd9), xl(32'h10, 32'hDEADBEEF, 5'd9));
    issue0(ld(32'h20, SZ_HALF, 1'b0, 5'd10), xl(32'h20, 32'hFFFF8044, 5'd10));
    issue0(ld(32'h22, SZ_HALF, 1'b1, 5'd11), xl(32'h22, 32'h00001122, 5'd11));
    issue0(ld(32'h12, SZ_WORD, 1'b0, 5'd12), '{32'h12, 32'h0, 5'd12, 1'b0, 1'b1, 1'b1});
    issue0('{1'b1, 32'h12345678, 32'h0, 5'd13, 1'b0, 1'b0, SZ_WORD, 1'b0, 1'b1, 1'b0},
           '{32'h12345678, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0});
    begin
      ex_t e;
      e = st(32'h30, 32'hCAFEF00D, SZ_WORD);
      e.rd = 1'b1;
      issue0(e, xs(32'h30));
    end
    issue0(ld(32'h30, SZ_WORD, 1'b0, 5'd14), xl(32'h30, 32'hCAFEF00D, 5'd14));
    issue0(st(32'h33, 32'h000000A5, SZ_BYTE), xs(32'h33));
    issue0(ld(32'h33, SZ_BYTE, 1'b1, 5'd15), xl(32'h33, 32'h000000A5, 5'd15));
    issue0(ld(32'h33, SZ_BYTE, 1'b0, 5'd16), xl(32'h33, 32'hFFFFFFA5, 5'd16));
    issue0(ld(32'h30, SZ_WORD, 1'b0, 5'd17), xl(32'h30, 32'hA5FEF00D, 5'd17));
    issue0(ld(32'h410, SZ_WORD, 1'b0, 5'd18), xl(32'h410, 32'hDEADBEEF, 5'd18));
    bubble0(st(32'h10, 32'h0, SZ_WORD), 1'b1);
    begin
      ex_t e;
      e = st(32'h10, 32'h0, SZ_WORD);
      e.valid = 1'b0;
      bubble0(e, 1'b0);
    end
    issue0(ld(32'h10, SZ_WORD, 1'b0, 5'd19), xl(32'h10, 32'hDEADBEEF, 5'd19));

    // Three wait states: timing, flush mid-access, reset mid-access.
    issue3(st(32'h40, 32'h55AA55AA, SZ_WORD), xs(32'h40));
    issue3(ld(32'h40, SZ_WORD, 1'b0, 5'd3), xl(32'h40, 32'h55AA55AA, 5'd3));

    ex3 = st(32'h40, 32'h0BADF00D, SZ_WORD);
    @(negedge clk);
    chk_b("flush_stall_c0", stall3, 1'b1);
    @(posedge clk); #1;
    flush3 = 1'b1;
    @(negedge clk);
    chk_b("flush_stall_c1", stall3, 1'b0);
    @(posedge clk); #1;
    flush3 = 1'b0;
    ex3 = '0;
    @(negedge clk);
    chk_b("flush_bubble", v3, 1'b0);
    @(posedge clk); #1;
    issue3(ld(32'h40, SZ_WORD, 1'b0, 5'd4), xl(32'h40, 32'h55AA55AA, 5'd4));

    ex3 = st(32'h40, 32'h12345678, SZ_WORD);
    @(posedge clk); #2;
    rst3_n = 1'b0;
    #1;
    chk_b("midrst_valid", v3, 1'b0);
    chk_w("midrst_alu", alu3, 32'h0);
    chk_w("midrst_rd", rd3, 32'h0);
    chk_w("midrst_dest", {27'h0, dest3}, 32'h0);
    chk_b("midrst_flags", rw3 | m2r3 | mis3, 1'b0);
    chk_b("midrst_stall", stall3, 1'b0);
    ex3 = '0;
    @(negedge clk);
    rst3_n = 1'b1;
    @(posedge clk); #1;
    issue3(ld(32'h40, SZ_WORD, 1'b0, 5'd2), xl(32'h40, 32'h55AA55AA, 5'd2));

    repeat (3) @(posedge clk);
    #1;
    chk_b("q0_drained", q0.size() == 0, 1'b1);
    chk_b("q3_drained", q3.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
